// File: rtl/gcd_job_feeder_m_if.sv
// Job-feeder bus: input job stream, result stream and the GCD core control/status lines.
// master = the feeder, slave = its environment (producer, consumer and core).
interface gcd_job_feeder_m_if #(
   parameter int WIDTH = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_gcd;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic             out_err;

   logic             gcd_start;
   logic             gcd_reset;
   logic [WIDTH-1:0] gcd_ain;
   logic [WIDTH-1:0] gcd_bin;
   logic [WIDTH-1:0] gcd_out;
   logic             gcd_valid;

   modport master (
      input  in_valid, in_a, in_b, out_ready, gcd_out, gcd_valid,
      output in_ready, out_valid, out_gcd, out_a, out_b, out_err,
             gcd_start, gcd_reset, gcd_ain, gcd_bin
   );

   modport slave (
      output in_valid, in_a, in_b, out_ready, gcd_out, gcd_valid,
      input  in_ready, out_valid, out_gcd, out_a, out_b, out_err,
             gcd_start, gcd_reset, gcd_ain, gcd_bin
   );
endinterface

// File: rtl/gcd_job_feeder_m.sv
// Job FIFO plus sequencer for the subtractive GCD core; zero operands bypass the core.
// Define GCD_FEED_TIMEOUT_EN to add a WAIT-state watchdog that aborts a stuck job with out_err.
module gcd_job_feeder_m #(
   parameter int WIDTH          = 6,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                clk,
   input logic                reset,
   gcd_job_feeder_m_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESULT} state_t;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("gcd_job_feeder_m: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
   end

   state_t           state;
   logic [WIDTH-1:0] fifo_a [FIFO_DEPTH];
   logic [WIDTH-1:0] fifo_b [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;

   logic             result_valid;
   logic [WIDTH-1:0] result_gcd;
   logic [WIDTH-1:0] job_a;
   logic [WIDTH-1:0] job_b;
   logic             start_pulse;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;

   // The extra pointer bit tells a full FIFO from an empty one when the indices match.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push   = bus.in_valid && bus.in_ready;
   assign pop    = (state == IDLE) && !empty;
   assign head_a = fifo_a[rd_ptr[PTR_W-1:0]];
   assign head_b = fifo_b[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a[wr_ptr[PTR_W-1:0]] <= bus.in_a;
         fifo_b[wr_ptr[PTR_W-1:0]] <= bus.in_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
         end
      end
   end

`ifdef GCD_FEED_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] wait_timer;
   logic             result_err;
`endif

   // gcd_valid is still high from the previous job during LAUNCH, so only WAIT looks at it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         result_valid <= 1'b0;
         result_gcd   <= '0;
         job_a        <= '0;
         job_b        <= '0;
         start_pulse  <= 1'b0;
         core_a       <= '0;
         core_b       <= '0;
`ifdef GCD_FEED_TIMEOUT_EN
         wait_timer   <= '0;
         result_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  job_a <= head_a;
                  job_b <= head_b;
                  if (head_a == '0 || head_b == '0) begin
                     result_gcd   <= head_a | head_b;
                     result_valid <= 1'b1;
`ifdef GCD_FEED_TIMEOUT_EN
                     result_err   <= 1'b0;
`endif
                     state        <= RESULT;
                  end else begin
                     core_a      <= head_a;
                     core_b      <= head_b;
                     start_pulse <= 1'b1;
                     state       <= LAUNCH;
                  end
               end
            end
            LAUNCH: begin
               start_pulse <= 1'b0;
`ifdef GCD_FEED_TIMEOUT_EN
               wait_timer  <= '0;
`endif
               state       <= WAIT;
            end
            WAIT: begin
               if (bus.gcd_valid) begin
                  result_gcd   <= bus.gcd_out;
                  result_valid <= 1'b1;
`ifdef GCD_FEED_TIMEOUT_EN
                  result_err   <= 1'b0;
`endif
                  state        <= RESULT;
               end
`ifdef GCD_FEED_TIMEOUT_EN
               else if (wait_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  result_gcd   <= '0;
                  result_err   <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= RESULT;
               end else begin
                  wait_timer <= wait_timer + TMR_W'(1);
               end
`endif
            end
            RESULT: begin
               if (bus.out_ready) begin
                  result_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = !full && !reset;
   assign bus.out_valid = result_valid;
   assign bus.out_gcd   = result_gcd;
   assign bus.out_a     = job_a;
   assign bus.out_b     = job_b;
   assign bus.gcd_start = start_pulse;
   assign bus.gcd_reset = reset;
   assign bus.gcd_ain   = core_a;
   assign bus.gcd_bin   = core_b;
`ifdef GCD_FEED_TIMEOUT_EN
   assign bus.out_err   = result_err;
`else
   assign bus.out_err   = 1'b0;
`endif
endmodule
